pad_share_arbiter: RTL and testbench
====================================

Name: pad_share_arbiter

Overview:
- Time-multiplexes one bidirectional pull-down pad cell (OEN/I/O/PEN/PAD interface) between NumReq on-chip requesters.
- Round-robin arbitration, bounded ownership time, and enforced turnaround cycles with the driver off and the pull enabled between owners, so two drivers never overlap.
- Sits between peripheral IO logic and the pad instance; also returns a synchronised, optionally filtered, copy of the pad input.

Parameters:
- NumReq, 4, number of requesters (>=2).
- TurnCycles, 2, dead cycles between owners (0..15); driver off, pull on.
- MaxHold, 16, OWN cycles after which the owner is pre-empted if another request is pending (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NumReq  per-requester pad request, level.
- oe_i  in  NumReq  per-requester drive-enable (1 = drive pad).
- data_i  in  NumReq  per-requester output data.
- gnt_o  out  NumReq  one-hot grant, registered.
- busy_o  out  1  high in TURN or OWN.
- rdata_o  out  1  synchronised pad input.
- pad_oen_o  out  1  to pad OEN (0 = drive).
- pad_i_o  out  1  to pad I.
- pad_pen_o  out  1  to pad PEN (0 = pull active).
- pad_o_i  in  1  from pad O.

Behaviour:
- Reset values (async, effective immediately):
  - gnt_o=0, busy_o=0, pad_oen_o=1, pad_i_o=0, pad_pen_o=0, rdata_o=0.
  - state=IDLE; last-owner pointer=NumReq-1, so index 0 has first priority.
- States: IDLE, TURN, OWN. The state and owner index are registered.
- IDLE:
  - Driver off, pull on.
  - Any req_i high at cycle t: winner = first requester at or after (last_owner+1) mod NumReq.
  - Winner latched. If TurnCycles>0, go to TURN at t+1; otherwise go to OWN at t+1.
- TURN:
  - Turn counter loads TurnCycles-1 and decrements each cycle.
  - Driver off, pull on.
  - At count 0, go to OWN. gnt_o rises in the OWN cycle: first grant at t+1+TurnCycles.
- Winner drops req during TURN: at the end of TURN, re-arbitrate among current requests.
  - Winner found: go straight to OWN for that winner, with no second TURN.
  - No requests: go to IDLE.
- OWN:
  - gnt_o[owner]=1.
  - Combinational from owner: pad_oen_o=~oe_i[owner], pad_i_o=data_i[owner]&oe_i[owner], pad_pen_o=oe_i[owner].
  - Pull is active whenever not driving.
  - Hold counter starts at 0 on entry and increments each OWN cycle, saturating at MaxHold-1.
- OWN exit conditions, evaluated at cycle c:
  - (a) req_i[owner]==0.
  - (b) hold==MaxHold-1 and any other req_i high.
  - Either condition: last_owner<=owner; at c+1 gnt_o=0, pad_oen_o=1, state goes to TURN (or to arbitration directly when TurnCycles=0). After TURN, go to arbitration or IDLE.
  - Hold saturated with no other request: owner keeps the pad indefinitely.
- Outputs outside OWN: pad_i_o=0 whenever not in OWN.
- Grant exclusivity: gnt_o is never multi-hot, and never high outside OWN.
- Simultaneous requests: priority is strictly round-robin from last_owner+1. A pre-empted owner that keeps requesting is served again only after every other pending requester.
- Requests raised mid-TURN: considered only at the re-arbitration point.
- Reset mid-OWN: pad_oen_o returns to 1 asynchronously; no partial drive persists.
- Input path: pad_o_i passes through a 2-flop synchroniser (reset 0) to rdata_o, latency 2 cycles. X on pad_o_i is not masked.

Optional Feature:
- PAD_SHARE_GLITCH_FILTER_EN defined:
  - Adds a filter after the synchroniser.
  - rdata_o updates only when the last 3 synchronised samples are equal.
  - Total latency 4 cycles for a clean edge. Pulses shorter than 3 cycles are suppressed.
  - Filter registers reset to 0.
- Not defined: rdata_o is the synchroniser output directly (2 cycles).

Test Plan:
- Reset, then idle: rst_ni low with all req_i=0 -> pad_oen_o=1, pad_pen_o=0, gnt_o=0, busy_o=0 throughout; rdata_o=0.
- Single request: req_i=4'b0100 at cycle 5, oe_i[2]=1, data_i[2]=1, TurnCycles=2 -> gnt_o=4'b0100 from cycle 8, pad_oen_o=0, pad_i_o=1, pad_pen_o=1. Drop req at cycle 12 -> gnt_o=0 and pad_oen_o=1 at cycle 13; busy_o low from cycle 15.
- Round-robin: req_i=4'b1111 held -> grant order 0,1,2,3,0. Each tenure is MaxHold=16 cycles, separated by exactly 2 turnaround cycles with pad_oen_o=1. gnt_o is never multi-hot.
- Pre-emption vs. no contention: requester 1 alone for 40 cycles -> keeps grant. Requester 3 asserts at cycle 20 of tenure -> requester 1 released at its next hold-saturated cycle; requester 3 granted after TurnCycles.
- Async reset mid-OWN: rst_ni low while requester 0 drives -> pad_oen_o=1 and gnt_o=0 the same cycle. After release, index 0 again has first priority.
- Input path: pad_o_i pulse of 1 cycle, then step 0->1 -> without macro, rdata_o shows both after 2 cycles. With PAD_SHARE_GLITCH_FILTER_EN, the pulse is suppressed and the step appears after 4 cycles.

Source files
------------

// File: rtl/pad_share_if.sv
// Requester-side bundle of the shared-pad arbiter: per-requester request/drive/data in,
// one-hot grant, busy flag and synchronised pad input back out.
interface pad_share_if #(
    parameter int unsigned NumReq = 4
);
    logic [NumReq-1:0] req_i;
    logic [NumReq-1:0] oe_i;
    logic [NumReq-1:0] data_i;
    logic [NumReq-1:0] gnt_o;
    logic              busy_o;
    logic              rdata_o;

    modport master (output req_i, oe_i, data_i, input gnt_o, busy_o, rdata_o);
    modport slave  (input req_i, oe_i, data_i, output gnt_o, busy_o, rdata_o);
endinterface

// File: rtl/pad_share_arbiter.sv
// Round-robin time-multiplexer of one pull-down pad cell between NumReq requesters, with
// bounded ownership and driver-off turnaround. PAD_SHARE_GLITCH_FILTER_EN adds an rdata_o filter.
module pad_share_arbiter #(
    parameter int unsigned NumReq     = 4,
    parameter int unsigned TurnCycles = 2,
    parameter int unsigned MaxHold    = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    pad_share_if.slave  bus,
    output logic        pad_oen_o,
    output logic        pad_i_o,
    output logic        pad_pen_o,
    input  logic        pad_o_i
);
    localparam int unsigned OwnW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned HoldW = (MaxHold > 1) ? $clog2(MaxHold) : 1;
    localparam int unsigned TurnW = 4;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StTurn = 2'd1;
    localparam logic [1:0] StOwn  = 2'd2;

    localparam logic [OwnW-1:0]  LastInit = OwnW'(NumReq - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(MaxHold - 1);
    localparam logic [TurnW-1:0] TurnInit = TurnW'(TurnCycles - 1);

    logic [1:0]        state_q, state_d;
    logic [OwnW-1:0]   owner_q, owner_d;
    logic [OwnW-1:0]   last_q, last_d;
    logic [TurnW-1:0]  turn_q, turn_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic              won_q, won_d;
    logic [NumReq-1:0] gnt_q, gnt_d;
    logic              busy_q, busy_d;

    logic              arb_valid;
    logic [OwnW-1:0]   arb_idx;
    logic [OwnW-1:0]   scan_idx;
    logic [NumReq-1:0] own_oh;
    logic              other_req;
    logic              in_own;
    logic              oe_own;

    function automatic logic [NumReq-1:0] onehot(input logic [OwnW-1:0] idx);
        return {{(NumReq-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin pick: first active request at or after last_q+1.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            scan_idx = OwnW'((32'(last_q) + 32'd1 + i) % NumReq);
            if (!arb_valid && bus.req_i[scan_idx]) begin
                arb_valid = 1'b1;
                arb_idx   = scan_idx;
            end
        end
    end

    assign own_oh    = onehot(owner_q);
    assign other_req = |(bus.req_i & ~own_oh);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        turn_d  = turn_q;
        hold_d  = hold_q;
        won_d   = won_q;
        gnt_d   = '0;
        case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    owner_d = arb_idx;
                    if (TurnCycles > 0) begin
                        state_d = StTurn;
                        turn_d  = TurnInit;
                        won_d   = 1'b1;
                    end else begin
                        state_d = StOwn;
                        hold_d  = '0;
                        gnt_d   = onehot(arb_idx);
                    end
                end
            end
            StTurn: begin
                if (turn_q == '0) begin
                    won_d = 1'b0;
                    // A winner from IDLE that still requests keeps its slot; otherwise re-arbitrate.
                    if (won_q && bus.req_i[owner_q]) begin
                        state_d = StOwn;
                        hold_d  = '0;
                        gnt_d   = own_oh;
                    end else if (arb_valid) begin
                        state_d = StOwn;
                        owner_d = arb_idx;
                        hold_d  = '0;
                        gnt_d   = onehot(arb_idx);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
            StOwn: begin
                if (!bus.req_i[owner_q] || (hold_q == HoldMax && other_req)) begin
                    last_d = owner_q;
                    won_d  = 1'b0;
                    if (TurnCycles > 0) begin
                        state_d = StTurn;
                        turn_d  = TurnInit;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    gnt_d = own_oh;
                    if (hold_q != HoldMax) hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= LastInit;
            turn_q  <= '0;
            hold_q  <= '0;
            won_q   <= 1'b0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            turn_q  <= turn_d;
            hold_q  <= hold_d;
            won_q   <= won_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    // Pad drive follows the registered state, so reset releases the driver immediately.
    assign in_own    = (state_q == StOwn);
    assign oe_own    = bus.oe_i[owner_q];
    assign pad_oen_o = in_own ? ~oe_own : 1'b1;
    assign pad_i_o   = in_own & oe_own & bus.data_i[owner_q];
    assign pad_pen_o = in_own & oe_own;

    assign bus.gnt_o  = gnt_q;
    assign bus.busy_o = busy_q;

    logic sync1_q, sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pad_o_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef PAD_SHARE_GLITCH_FILTER_EN
    logic filt_q, rdata_q;

    // Three consecutive chain samples must agree before rdata moves.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q  <= 1'b0;
            rdata_q <= 1'b0;
        end else begin
            filt_q <= sync2_q;
            if (sync1_q == sync2_q && sync2_q == filt_q) rdata_q <= sync2_q;
        end
    end

    assign bus.rdata_o = rdata_q;
`else
    assign bus.rdata_o = sync2_q;
`endif

endmodule

// File: tb/tb_pad_share_arbiter.sv
// Directed bench for pad_share_arbiter: reset, single grant, round-robin, pre-emption,
// async reset mid-drive and the pad input path (both filter builds).
module tb_pad_share_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pad_oen, pad_i, pad_pen;
    logic pad_o = 1'b0;
    int   total = 0;
    int   bad   = 0;

    pad_share_if #(.NumReq(4)) bus ();

    pad_share_arbiter #(.NumReq(4), .TurnCycles(2), .MaxHold(16)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .bus      (bus),
        .pad_oen_o(pad_oen),
        .pad_i_o  (pad_i),
        .pad_pen_o(pad_pen),
        .pad_o_i  (pad_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_i = '0; bus.oe_i = '0; bus.data_i = '0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(output int gap, output int drive_in_gap);
        gap = 0; drive_in_gap = 0;
        while (bus.gnt_o == '0 && gap < 200) begin
            if (!pad_oen) drive_in_gap++;
            tick(); gap++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy_o && n < 200) begin tick(); n++; end
        chk("idle", 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        logic [3:0] exp_g [5];
        logic [3:0] g;
        logic [5:0] v;
        int gap, drv, len, mh, lost;

        bus.req_i = '0; bus.oe_i = '0; bus.data_i = '0;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset then idle
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_oen", 32'(pad_oen), 32'd1);
            chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
            tick();
        end
        chk("rst_pen", 32'(pad_pen), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_rdata", 32'(bus.rdata_o), 32'd0);
        rst_n = 1'b1;
        tick(); tick();
        chk("idle_busy", 32'(bus.busy_o), 32'd0);
        chk("idle_oen", 32'(pad_oen), 32'd1);

        // Single request on index 2 with drive
        bus.req_i = 4'b0100; bus.oe_i = 4'b0100; bus.data_i = 4'b0100;
        tick();
        chk("s_t1_gnt", 32'(bus.gnt_o), 32'd0);
        chk("s_t1_busy", 32'(bus.busy_o), 32'd1);
        chk("s_t1_oen", 32'(pad_oen), 32'd1);
        tick();
        chk("s_t2_gnt", 32'(bus.gnt_o), 32'd0);
        tick();
        chk("s_own_gnt", 32'(bus.gnt_o), 32'h4);
        chk("s_own_oen", 32'(pad_oen), 32'd0);
        chk("s_own_i", 32'(pad_i), 32'd1);
        chk("s_own_pen", 32'(pad_pen), 32'd1);
        tick(); tick(); tick(); tick();
        bus.req_i = '0;
        tick();
        chk("s_rel_gnt", 32'(bus.gnt_o), 32'd0);
        chk("s_rel_oen", 32'(pad_oen), 32'd1);
        chk("s_rel_i", 32'(pad_i), 32'd0);
        chk("s_rel_busy", 32'(bus.busy_o), 32'd1);
        tick();
        chk("s_turn_busy", 32'(bus.busy_o), 32'd1);
        tick();
        chk("s_end_busy", 32'(bus.busy_o), 32'd0);

        // Round-robin with all four requesting
        do_reset();
        bus.req_i = 4'b1111;
        mh = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(gap, drv);
            chk("rr_gap", 32'(gap), (k == 0) ? 32'd3 : 32'd2);
            chk("rr_gap_drive", 32'(drv), 32'd0);
            g = bus.gnt_o;
            chk("rr_owner", 32'(g), 32'(exp_g[k]));
            len = 0;
            while (bus.gnt_o == g && g != '0 && len < 200) begin
                if (!$onehot(bus.gnt_o)) mh++;
                tick(); len++;
            end
            chk("rr_len", 32'(len), 32'd16);
        end
        chk("rr_multihot", 32'(mh), 32'd0);
        bus.req_i = '0;
        wait_idle();

        // No contention keeps the grant; contention pre-empts at hold saturation
        do_reset();
        bus.req_i = 4'b0010;
        wait_gnt(gap, drv);
        chk("pe_gnt", 32'(bus.gnt_o), 32'h2);
        lost = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.gnt_o != 4'b0010) lost++;
        end
        chk("pe_keep", 32'(lost), 32'd0);
        bus.req_i = 4'b1010;
        tick();
        chk("pe_rel_gnt", 32'(bus.gnt_o), 32'd0);
        tick();
        chk("pe_turn_gnt", 32'(bus.gnt_o), 32'd0);
        chk("pe_turn_oen", 32'(pad_oen), 32'd1);
        tick();
        chk("pe_new_gnt", 32'(bus.gnt_o), 32'h8);
        bus.req_i = '0;
        wait_idle();

        // Async reset while requester 0 drives; pointer must return to index 0
        do_reset();
        bus.req_i = 4'b0100;
        wait_gnt(gap, drv);
        bus.req_i = '0;
        wait_idle();
        bus.req_i = 4'b0001; bus.oe_i = 4'b0001; bus.data_i = 4'b0001;
        wait_gnt(gap, drv);
        chk("ar_gnt", 32'(bus.gnt_o), 32'h1);
        chk("ar_oen", 32'(pad_oen), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rst_oen", 32'(pad_oen), 32'd1);
        chk("ar_rst_gnt", 32'(bus.gnt_o), 32'd0);
        chk("ar_rst_i", 32'(pad_i), 32'd0);
        chk("ar_rst_pen", 32'(pad_pen), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.req_i = 4'b1111; bus.oe_i = '0; bus.data_i = '0;
        wait_gnt(gap, drv);
        chk("ar_prio0", 32'(bus.gnt_o), 32'h1);
        bus.req_i = '0;
        wait_idle();

        // Pad input path: one-cycle pulse, then a step
        do_reset();
        tick(); tick(); tick(); tick();
        pad_o = 1'b1;
        v = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) pad_o = 1'b0;
            v[i] = bus.rdata_o;
        end
`ifdef PAD_SHARE_GLITCH_FILTER_EN
        chk("in_pulse", 32'(v), 32'h00);
`else
        chk("in_pulse", 32'(v), 32'h02);
`endif
        tick(); tick(); tick(); tick();
        pad_o = 1'b1;
        v = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            v[i] = bus.rdata_o;
        end
`ifdef PAD_SHARE_GLITCH_FILTER_EN
        chk("in_step", 32'(v), 32'h38);
`else
        chk("in_step", 32'(v), 32'h3e);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
